// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register for back-to-back frames.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned CNT_W        = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       TxD,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic [7:0]       shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic             txd_q;
  logic             tx_ready_q;
  logic             tx_busy_q;
  logic             tx_done_q;

  assign TxD      = txd_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

  // Holding-register handshake plus frame sequencer; every output is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      txd_q       <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;

      // Accept into the holding register; cannot coincide with a drain.
      if (tx_valid && tx_ready_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
        tx_ready_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          txd_q     <= 1'b1;
          tx_busy_q <= 1'b0;
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            cnt_q       <= '0;
            state_q     <= START;
            txd_q       <= 1'b0;
            tx_busy_q   <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            state_q   <= DATA;
            txd_q     <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              // LSB-first: shift the byte down so the next bit is always at [1].
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        STOP: begin
          // Pulse lands on the last stop-bit cycle.
          if (cnt_q == CNT_PRE) begin
            tx_done_q <= 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              tx_ready_q  <= 1'b1;
              state_q     <= START;
              txd_q       <= 1'b0;
            end else begin
              state_q   <= IDLE;
              txd_q     <= 1'b1;
              tx_busy_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q   <= IDLE;
          txd_q     <= 1'b1;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame scoreboard plus targeted timing checks.
module tb_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       TxD;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rx_cnt = 0;
  int ncyc = 0;
  int last_acc = 0;

  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[4];

  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .TxD      (TxD),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a byte until accepted; pushes the expected frame at the acceptance edge.
  task automatic send(input logic [7:0] d, input logic [9:0] f, input bit jitter);
    int n;
    n = 0;
    tx_valid = 1'b1;
    tx_data  = jitter ? 8'($urandom) : d;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
      if (jitter && !tx_ready) tx_data = 8'($urandom);
    end
    chk("accept_timeout", 64'(n < 200), 64'(1));
    tx_data = d;
    @(posedge clk);
    last_acc = ncyc;
    exp_q.push_back(f);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n < 600), 64'(1));
  endtask

  function automatic logic [9:0] mkf(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Line monitor: captures 40 cycles from a start bit and compares to the scoreboard.
  initial begin : monitor
    logic [39:0] line_a, line_e, done_a, done_e, busy_a;
    logic [9:0]  f;
    bit          ok;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && TxD === 1'b0) begin
        ok = 1'b1;
        line_a[0] = TxD; done_a[0] = tx_done; busy_a[0] = tx_busy;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (reset !== 1'b1) begin
            ok = 1'b0;
            break;
          end
          line_a[i] = TxD; done_a[i] = tx_done; busy_a[i] = tx_busy;
        end
        if (ok) begin
          rx_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 64'(line_a), 64'(0));
          end else begin
            f = exp_q.pop_front();
            for (int i = 0; i < 40; i++) begin
              line_e[i] = f[i / CPB];
              done_e[i] = (i == 39);
            end
            chk("frame_line", 64'(line_a), 64'(line_e));
            chk("frame_done", 64'(done_a), 64'(done_e));
            chk("frame_busy", 64'(busy_a), {24'd0, 40'hFF_FFFF_FFFF});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};

    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(posedge clk);

    // 1. Asynchronous reset mid-clock, valid ignored while held.
    #3 reset = 1'b0;
    #1;
    chk("rst_txd", 64'(TxD), 64'(1));
    chk("rst_ready", 64'(tx_ready), 64'(1));
    chk("rst_busy", 64'(tx_busy), 64'(0));
    chk("rst_done", 64'(tx_done), 64'(0));
    tx_valid = 1'b1; tx_data = 8'h99;
    repeat (5) begin
      @(negedge clk);
      chk("rst_hold_busy", 64'(tx_busy), 64'(0));
      chk("rst_hold_txd", 64'(TxD), 64'(1));
    end
    reset = 1'b1; tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 64'(tx_busy), 64'(0));
    chk("post_rst_ready", 64'(tx_ready), 64'(1));

    // 2. Table-driven single frames with latency and frame-end boundaries.
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].data, vecs[v].frame, 1'b0);
      tx_valid = 1'b0;
      @(negedge clk);                       // cycle E
      chk("lat_ready_E", 64'(tx_ready), 64'(0));
      chk("lat_txd_E", 64'(TxD), 64'(1));
      @(negedge clk);                       // cycle E+1
      chk("lat_txd_E1", 64'(TxD), 64'(0));
      chk("lat_busy_E1", 64'(tx_busy), 64'(1));
      chk("lat_ready_E1", 64'(tx_ready), 64'(1));
      repeat (40) @(negedge clk);           // cycle E+41
      chk("end_busy", 64'(tx_busy), 64'(0));
      chk("end_done", 64'(tx_done), 64'(0));
      chk("end_txd", 64'(TxD), 64'(1));
      wait_idle();
    end
    chk("done_cnt_single", 64'(done_cnt), 64'(4));

    // 3. Back-to-back: no idle gap, done pulses 40 cycles apart.
    send(8'h00, mkf(8'h00), 1'b0);
    base = last_acc;
    tx_valid = 1'b0;
    @(negedge clk);                         // cycle E
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge clk);                         // cycle E+1
    chk("b2b_ready_E1", 64'(tx_ready), 64'(1));
    @(posedge clk);                         // edge E+2 accepts 0xFF
    exp_q.push_back(mkf(8'hFF));
    #1 tx_valid = 1'b0;
    @(negedge clk);                         // cycle E+2
    chk("b2b_ready_E2", 64'(tx_ready), 64'(0));
    repeat (38) @(negedge clk);             // cycle E+40
    chk("b2b_done1", 64'(tx_done), 64'(1));
    chk("b2b_ready_E40", 64'(tx_ready), 64'(0));
    @(negedge clk);                         // cycle E+41
    chk("b2b_gap_txd", 64'(TxD), 64'(0));
    chk("b2b_gap_busy", 64'(tx_busy), 64'(1));
    chk("b2b_ready_E41", 64'(tx_ready), 64'(1));
    chk("b2b_done_off", 64'(tx_done), 64'(0));
    repeat (39) @(negedge clk);             // cycle E+80
    chk("b2b_done2", 64'(tx_done), 64'(1));
    wait_idle();
    chk("b2b_base", 64'(base > 0), 64'(1));

    // 4. Backpressure with valid held high.
    send(8'h11, mkf(8'h11), 1'b0);
    base = last_acc;
    send(8'h22, mkf(8'h22), 1'b0);
    chk("bp_acc2", 64'(last_acc - base), 64'(2));
    send(8'h33, mkf(8'h33), 1'b0);
    chk("bp_acc3", 64'(last_acc - base), 64'(42));
    tx_valid = 1'b0;
    wait_idle();

    // 5. Reset during data bit 3 with a byte queued.
    send(8'hC3, mkf(8'hC3), 1'b0);
    tx_valid = 1'b0;
    @(negedge clk);                         // cycle E
    send(8'h5A, mkf(8'h5A), 1'b0);          // accepted at edge E+2
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);             // cycle E+18, bit 3 (=0) on the line
    chk("mid_bit3", 64'(TxD), 64'(0));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_txd", 64'(TxD), 64'(1));
    chk("mid_rst_busy", 64'(tx_busy), 64'(0));
    chk("mid_rst_ready", 64'(tx_ready), 64'(1));
    exp_q.delete();
    base = done_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("mid_no_done", 64'(done_cnt), 64'(base));
    chk("mid_no_5a", 64'(tx_busy), 64'(0));
    send(8'h3C, mkf(8'h3C), 1'b0);
    tx_valid = 1'b0;
    wait_idle();

    // 6. Data jitter while not ready: only the acceptance-edge value is sent.
    send(8'h81, mkf(8'h81), 1'b0);
    send(8'h42, mkf(8'h42), 1'b0);
    send(8'h6E, mkf(8'h6E), 1'b1);
    tx_valid = 1'b0;
    wait_idle();

    repeat (10) @(negedge clk);
    chk("final_queue", 64'(exp_q.size()), 64'(0));
    chk("final_done_cnt", 64'(done_cnt), 64'(13));
    chk("final_rx_cnt", 64'(rx_cnt), 64'(13));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
